// File: rtl/display_arbiter_if.sv
// Bundle between the two interface decoders, the arbiter and the display mux.
// The master side drives the function codes and priority; the arbiter is the slave.
interface display_arbiter_if;
  logic [2:0] func1;
  logic [2:0] func2;
  logic       priorsel;
  logic       displaysel;
  logic       grant1;
  logic       grant2;
  logic       blank;
  logic       locked;

  modport master (
    output func1, func2, priorsel,
    input  displaysel, grant1, grant2, blank, locked
  );

  modport slave (
    input  func1, func2, priorsel,
    output displaysel, grant1, grant2, blank, locked
  );
endinterface

// File: rtl/display_arbiter.sv
// Shares one 7-segment display between IE01 and IE02 with a minimum hold time
// and a blanking gap on every handover; all outputs are registered (Moore).
module display_arbiter #(
  parameter int HOLD_CYCLES  = 8,
  parameter int BLANK_CYCLES = 2,
  parameter int CNT_W        = 4
) (
  input logic               clk,
  input logic               rst_n,
  display_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, OWN1, OWN2, BLANK} state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] BLANK_MAX = CNT_W'(BLANK_CYCLES);
  localparam logic [2:0]       FUNC_LOCK = 3'b010;

  state_t           r_state, w_nextState;
  logic             r_tgt, w_nextTgt;
  logic [CNT_W-1:0] r_holdCnt, w_nextHold, w_holdInc;
  logic [CNT_W-1:0] r_blankCnt, w_nextBlank, w_blankInc;
  logic             r_displaysel, w_nextDisplaysel;
  logic             r_grant1, r_grant2, r_blank, r_locked;
  logic             w_nextLocked;
  logic             w_req1, w_req2, w_holdDone, w_blankDone;

  function automatic state_t arbitrate(input logic r1, input logic r2, input logic ps);
    if (r1 && r2) return ps ? OWN2 : OWN1;
    if (r1)       return OWN1;
    if (r2)       return OWN2;
    return IDLE;
  endfunction

  assign w_req1 = |bus.func1;
  assign w_req2 = |bus.func2;

  // The cycle ending at this edge counts, so the hold/blank lasts exactly N cycles.
  assign w_holdInc   = (r_holdCnt == HOLD_MAX) ? HOLD_MAX : r_holdCnt + 1'b1;
  assign w_holdDone  = (w_holdInc == HOLD_MAX);
  assign w_blankInc  = r_blankCnt + 1'b1;
  assign w_blankDone = (w_blankInc >= BLANK_MAX);

  always_comb begin
    w_nextState = r_state;
    w_nextTgt   = r_tgt;
    unique case (r_state)
      IDLE: w_nextState = arbitrate(w_req1, w_req2, bus.priorsel);
      OWN1: begin
        if (!w_req1) begin
          w_nextState = w_req2 ? BLANK : IDLE;
          w_nextTgt   = w_req2 ? 1'b1 : r_tgt;
        end else if (w_req2 && bus.priorsel && w_holdDone && !r_locked) begin
          w_nextState = BLANK;
          w_nextTgt   = 1'b1;
        end
      end
      OWN2: begin
        if (!w_req2) begin
          w_nextState = w_req1 ? BLANK : IDLE;
          w_nextTgt   = w_req1 ? 1'b0 : r_tgt;
        end else if (w_req1 && !bus.priorsel && w_holdDone && !r_locked) begin
          w_nextState = BLANK;
          w_nextTgt   = 1'b0;
        end
      end
      BLANK: begin
        if (w_blankDone) begin
          if (r_tgt && w_req2)        w_nextState = OWN2;
          else if (!r_tgt && w_req1)  w_nextState = OWN1;
          else                        w_nextState = arbitrate(w_req1, w_req2, bus.priorsel);
        end
      end
      default: w_nextState = IDLE;
    endcase

    w_nextHold  = ((w_nextState == OWN1 || w_nextState == OWN2) && w_nextState == r_state)
                  ? w_holdInc : '0;
    w_nextBlank = (w_nextState == BLANK && r_state == BLANK) ? w_blankInc : '0;

    w_nextDisplaysel = r_displaysel;
    w_nextLocked     = 1'b0;
    unique case (w_nextState)
      OWN1: begin
        w_nextDisplaysel = 1'b0;
        w_nextLocked     = (bus.func1 == FUNC_LOCK);
      end
      OWN2: begin
        w_nextDisplaysel = 1'b1;
        w_nextLocked     = (bus.func2 == FUNC_LOCK);
      end
      BLANK:   w_nextDisplaysel = w_nextTgt;
      default: w_nextDisplaysel = r_displaysel;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_tgt        <= 1'b0;
      r_holdCnt    <= '0;
      r_blankCnt   <= '0;
      r_displaysel <= 1'b0;
      r_grant1     <= 1'b0;
      r_grant2     <= 1'b0;
      r_blank      <= 1'b1;
      r_locked     <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_tgt        <= w_nextTgt;
      r_holdCnt    <= w_nextHold;
      r_blankCnt   <= w_nextBlank;
      r_displaysel <= w_nextDisplaysel;
      r_grant1     <= (w_nextState == OWN1);
      r_grant2     <= (w_nextState == OWN2);
      r_blank      <= (w_nextState == IDLE) || (w_nextState == BLANK);
      r_locked     <= w_nextLocked;
    end
  end

  assign bus.displaysel = r_displaysel;
  assign bus.grant1     = r_grant1;
  assign bus.grant2     = r_grant2;
  assign bus.blank      = r_blank;
  assign bus.locked     = r_locked;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter; outputs packed as {displaysel, grant1, grant2, blank, locked}.
module tb_display_arbiter;
  logic clk;
  logic rst_n;
  int   checkCount;
  int   errorCount;

  display_arbiter_if bus();

  display_arbiter #(
    .HOLD_CYCLES(8),
    .BLANK_CYCLES(2),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {bus.displaysel, bus.grant1, bus.grant2, bus.blank, bus.locked};
  endfunction

  task automatic checkOutput(input string tag, input logic [4:0] observed, input logic [4:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %b expected %b (D G1 G2 B L)", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] f1, input logic [2:0] f2, input logic ps);
    bus.func1    = f1;
    bus.func2    = f2;
    bus.priorsel = ps;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n = 1'b0;
    applyStimulus(3'b011, 3'b000, 1'b0);
    #22;
    checkOutput("reset", outs(), 5'b00010);
    tick();
    checkOutput("reset_held", outs(), 5'b00010);
    rst_n = 1'b1;
    tick();
    checkOutput("reset_release_own1", outs(), 5'b01000);

    applyStimulus(3'b001, 3'b101, 1'b1);
    for (int i = 1; i < 8; i++) begin
      tick();
      checkOutput($sformatf("preempt_hold%0d", i), outs(), 5'b01000);
    end
    tick();
    checkOutput("preempt_blank1", outs(), 5'b10010);
    tick();
    checkOutput("preempt_blank2", outs(), 5'b10010);
    tick();
    checkOutput("preempt_own2", outs(), 5'b10100);

    applyStimulus(3'b000, 3'b000, 1'b1);
    tick();
    checkOutput("idle_retains_sel", outs(), 5'b10010);
    applyStimulus(3'b001, 3'b100, 1'b1);
    tick();
    checkOutput("contention_own2", outs(), 5'b10100);

    applyStimulus(3'b000, 3'b000, 1'b1);
    tick();
    checkOutput("idle_before_lock", outs(), 5'b10010);
    applyStimulus(3'b010, 3'b000, 1'b1);
    tick();
    checkOutput("lock_own1", outs(), 5'b01001);
    applyStimulus(3'b010, 3'b101, 1'b1);
    for (int i = 0; i < 12; i++) begin
      tick();
      checkOutput($sformatf("lock_hold%0d", i), outs(), 5'b01001);
    end
    applyStimulus(3'b000, 3'b101, 1'b1);
    tick();
    checkOutput("lock_release_blank1", outs(), 5'b10010);
    tick();
    checkOutput("lock_release_blank2", outs(), 5'b10010);
    tick();
    checkOutput("lock_release_own2", outs(), 5'b10100);

    applyStimulus(3'b000, 3'b000, 1'b0);
    tick();
    checkOutput("idle_before_wait", outs(), 5'b10010);
    applyStimulus(3'b001, 3'b000, 1'b0);
    tick();
    checkOutput("wait_own1", outs(), 5'b01000);
    applyStimulus(3'b001, 3'b110, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput($sformatf("nonprio_wait%0d", i), outs(), 5'b01000);
    end
    applyStimulus(3'b000, 3'b110, 1'b0);
    tick();
    checkOutput("wait_blank1", outs(), 5'b10010);
    tick();
    checkOutput("wait_blank2", outs(), 5'b10010);
    tick();
    checkOutput("wait_own2", outs(), 5'b10100);

    applyStimulus(3'b000, 3'b000, 1'b0);
    tick();
    checkOutput("idle_before_drop", outs(), 5'b10010);
    applyStimulus(3'b011, 3'b000, 1'b0);
    tick();
    checkOutput("drop_own1", outs(), 5'b01000);
    applyStimulus(3'b011, 3'b101, 1'b1);
    repeat (7) tick();
    checkOutput("drop_still_own1", outs(), 5'b01000);
    tick();
    checkOutput("drop_blank1", outs(), 5'b10010);
    applyStimulus(3'b011, 3'b000, 1'b1);
    tick();
    checkOutput("drop_blank2", outs(), 5'b10010);
    tick();
    checkOutput("drop_rearb_own1", outs(), 5'b01000);

    rst_n = 1'b0;
    #2;
    checkOutput("midop_reset", outs(), 5'b00010);
    applyStimulus(3'b000, 3'b000, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("after_reset_idle", outs(), 5'b00010);

    applyStimulus(3'b000, 3'b001, 1'b0);
    tick();
    checkOutput("rev_own2", outs(), 5'b10100);
    applyStimulus(3'b100, 3'b001, 1'b0);
    repeat (7) tick();
    checkOutput("rev_hold_end", outs(), 5'b10100);
    tick();
    checkOutput("rev_blank1_sel0", outs(), 5'b00010);
    tick();
    checkOutput("rev_blank2_sel0", outs(), 5'b00010);
    tick();
    checkOutput("rev_own1", outs(), 5'b01000);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
